// File: rtl/cpa_pkg.sv
// Shared definitions for the pipelined carry-propagate adder: default geometry,
// stage-count helper and parameter sanity check.
package cpa_pkg;

  localparam int CPA_N   = 16;
  localparam int CPA_SEG = 4;

  function automatic int cpa_stages(input int n, input int seg);
    return n / seg;
  endfunction

  function automatic bit cpa_params_ok(input int n, input int seg);
    return (seg >= 1) && (n >= seg) && ((n % seg) == 0);
  endfunction

  localparam int CPA_K = cpa_stages(CPA_N, CPA_SEG);

  // One pipeline token at the default width: valid flag, partial sum, carry.
  typedef struct packed {
    logic              valid;
    logic [CPA_N-1:0]  sum;
    logic              carry;
  } cpa_token_t;

endpackage

// File: rtl/cpa_segment.sv
// Combinational SEG-bit ripple adder built from full adders; also exposes the
// carry into its MSB so the caller can detect signed overflow.
module cpa_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           c_msb_o
);

  for (genvar gi = 0; gi < SEG; gi++) begin : g_fa
    logic ci;
    logic co;
    if (gi == 0) begin : g_first
      assign ci = cin_i;
    end else begin : g_chain
      assign ci = g_fa[gi-1].co;
    end
    assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ ci;
    assign co        = (a_i[gi] & b_i[gi]) | (ci & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o  = g_fa[SEG-1].co;
  assign c_msb_o = g_fa[SEG-1].ci;

endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined N-bit adder/subtractor: one SEG-bit segment resolved per stage,
// operands skewed forward and resolved sums carried along, global stall.
module pipelined_cpa
  import cpa_pkg::*;
#(
  parameter int N   = CPA_N,
  parameter int SEG = CPA_SEG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int K = cpa_stages(N, SEG);

  if (!cpa_params_ok(N, SEG)) begin : g_param_check
    $error("pipelined_cpa: N must be a positive multiple of SEG");
  end

  logic         adv;
  logic [N-1:0] b_eff_d;
  logic         cin_eff_d;
  logic         v0_q;
  logic [N-1:0] a0_q;
  logic [N-1:0] b0_q;
  logic         c0_q;
  logic         ovf_q;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign b_eff_d   = in_b ^ {N{in_sub}};
  assign cin_eff_d = in_sub | in_cin;

  // Entry rank: conditioned operands are captured before any segment is added.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
      c0_q <= 1'b0;
    end else if (adv) begin
      v0_q <= in_valid;
      a0_q <= in_a;
      b0_q <= b_eff_d;
      c0_q <= cin_eff_d;
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_stage
    localparam int W = N - gi * SEG;  // operand bits still unresolved on entry
    localparam int R = gi * SEG;      // sum bits already resolved on entry

    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic             c_in;
    logic             v_in;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic             seg_cmsb;
    logic [R+SEG-1:0] sum_d;
    logic [R+SEG-1:0] sum_q;
    logic             carry_q;
    logic             valid_q;

    if (gi == 0) begin : g_head
      assign a_in  = a0_q;
      assign b_in  = b0_q;
      assign c_in  = c0_q;
      assign v_in  = v0_q;
      assign sum_d = seg_sum;
    end else begin : g_body
      assign a_in  = g_stage[gi-1].g_skew.a_q;
      assign b_in  = g_stage[gi-1].g_skew.b_q;
      assign c_in  = g_stage[gi-1].carry_q;
      assign v_in  = g_stage[gi-1].valid_q;
      assign sum_d = {seg_sum, g_stage[gi-1].sum_q};
    end

    cpa_segment #(.SEG(SEG)) u_seg (
      .a_i     (a_in[SEG-1:0]),
      .b_i     (b_in[SEG-1:0]),
      .cin_i   (c_in),
      .sum_o   (seg_sum),
      .cout_o  (seg_cout),
      .c_msb_o (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= v_in;
        carry_q <= seg_cout;
        sum_q   <= sum_d;
      end
    end

    if (gi < K - 1) begin : g_skew
      logic [W-SEG-1:0] a_q;
      logic [W-SEG-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[W-1:SEG];
          b_q <= b_in[W-1:SEG];
        end
      end
    end

    if (gi == K - 1) begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= seg_cmsb ^ seg_cout;
        end
      end
    end else begin : g_mid
      // Only the top segment's MSB carry matters for signed overflow.
      logic unused_cmsb;
      assign unused_cmsb = seg_cmsb;
    end
  end

  assign out_valid = g_stage[K-1].valid_q;
  assign out_sum   = g_stage[K-1].sum_q;
  assign out_cout  = g_stage[K-1].carry_q;
  assign out_ovf   = ovf_q;

endmodule
